cap_trig: RTL and testbench



---
 rtl/cap_trig.sv | 127 ++++++++++++
 tb/tb_cap_trig.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cap_trig.sv
// rtl/cap_trig.sv - triggered multi-channel probe capture with valid/ready readout
module cap_trig #(
  parameter int CH_NUM = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int CW     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] probe_signal,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        trig_mode,
  input  logic [CW-1:0]     trig_ch,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [CH_NUM-1:0] rd_data,
  output logic              rd_last
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_READOUT} state_t;

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW:0]   CH_LIM   = (CW + 1)'(CH_NUM);

  state_t state, state_nxt;

  // Probe flops must survive optimisation so the probed nets keep their load.
  (* dont_touch = "true" *) logic [CH_NUM-1:0] probe_q;
  (* dont_touch = "true" *) logic [CH_NUM-1:0] prev_q;

  logic [CH_NUM-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [1:0]        mode_r;
  logic [CW-1:0]     ch_r;
  logic              done_r;
  logic              hit;
  logic              ch_ok;
  logic              cap_end;
  logic              mem_we;
  logic [AW-1:0]     mem_wa;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      probe_q <= '0;
      prev_q  <= '0;
    end else begin
      probe_q <= probe_signal;
      prev_q  <= probe_q;
    end
  end

  always_comb begin
    ch_ok = ({1'b0, ch_r} < CH_LIM);
    hit   = 1'b0;
    case (mode_r)
      2'd0:    hit = 1'b1;
      2'd1:    hit = ch_ok && probe_q[ch_r] && !prev_q[ch_r];
      2'd2:    hit = ch_ok && !probe_q[ch_r] && prev_q[ch_r];
      default: hit = |(probe_q ^ prev_q);
    endcase
  end

  assign cap_end = (state == S_CAPTURE) && (wr_ptr == LAST_PTR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (arm) state_nxt = S_ARMED;
        S_ARMED:   if (hit) state_nxt = S_CAPTURE;
        S_CAPTURE: if (wr_ptr == LAST_PTR) state_nxt = S_READOUT;
        S_READOUT: if (rd_ready && rd_ptr == LAST_PTR) state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state == S_ARMED) || (state == S_CAPTURE);
    done     = done_r;
    rd_valid = (state == S_READOUT);
    rd_last  = rd_valid && (rd_ptr == LAST_PTR);
    rd_data  = rd_valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mode_r <= '0;
      ch_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= cap_end && !abort;
      if (!abort && state == S_IDLE && arm) begin
        mode_r <= trig_mode;
        ch_r   <= trig_ch;
      end
      if (abort)                        wr_ptr <= '0;
      else if (state == S_ARMED && hit) wr_ptr <= AW'(1);
      else if (state == S_CAPTURE)      wr_ptr <= wr_ptr + AW'(1);
      else                              wr_ptr <= '0;
      if (abort || cap_end)                     rd_ptr <= '0;
      else if (state == S_READOUT && rd_ready)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Trigger sample always lands in element 0; capture continues from wr_ptr.
  assign mem_we = !abort && ((state == S_ARMED && hit) || state == S_CAPTURE);
  assign mem_wa = (state == S_CAPTURE) ? wr_ptr : '0;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= probe_q;
  end

endmodule

// File: tb/tb_cap_trig.sv
// tb/tb_cap_trig.sv - scoreboard bench for cap_trig with a behavioural capture model
module tb_cap_trig;
  localparam int CH    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] probe_signal;
  logic          arm, abort, rd_ready;
  logic [1:0]    trig_mode;
  logic [CW-1:0] trig_ch;
  logic          busy, done, rd_valid, rd_last;
  logic [CH-1:0] rd_data;

  cap_trig #(.CH_NUM(CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .probe_signal(probe_signal), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_ch(trig_ch), .busy(busy), .done(done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  typedef struct {logic [CH-1:0] d; logic l;} exp_t;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Readout monitor: pops the scoreboard on every transfer and checks stall stability.
  bit            stall_prev = 1'b0;
  logic [CH-1:0] stall_d;
  logic          stall_l;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (rd_valid && stall_prev) begin
        check("stall_data", {rd_last, rd_data}, {stall_l, stall_d});
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_transfer: got data %0h with empty scoreboard", rd_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rd_data", rd_data, e.d);
          check("rd_last", rd_last, e.l);
        end
      end
      stall_prev = rd_valid && !rd_ready;
      stall_d    = rd_data;
      stall_l    = rd_last;
    end
  end

  function automatic bit model_hit(input int mode, input int ch, input logic [CH-1:0] cur,
                                   input logic [CH-1:0] prv);
    case (mode)
      0:       return 1'b1;
      1:       return cur[ch] && !prv[ch];
      2:       return !cur[ch] && prv[ch];
      default: return cur != prv;
    endcase
  endfunction

  // pq[n] is the probe value seen at clock edge n of the scenario; arm is seen at edge a_idx.
  task automatic run_scn(input string tag, input logic [CH-1:0] pq[$], input int a_idx,
                         input int mode, input int ch, input int abort_n, input bit bp);
    int j = -1;
    int done_edge = -1;
    int busy_end, stop_min;
    bit armed_ok, captured;
    armed_ok = (abort_n < 0) || (abort_n > a_idx);
    if (armed_ok) begin
      for (int k = a_idx; k < pq.size(); k++) begin
        if (model_hit(mode, ch, pq[k], pq[k-1])) begin
          j = k;
          break;
        end
      end
    end
    if (j < 0 && abort_n < 0) abort_n = pq.size();
    if (j >= 0) while (pq.size() < j + DEPTH + 1) pq.push_back(CH'($urandom));
    captured = (j >= 0) && (abort_n < 0 || abort_n > j + DEPTH);
    if (captured) begin
      for (int k = 0; k < DEPTH; k++) exp_q.push_back('{pq[j+k], k == DEPTH - 1});
      done_edge = j + DEPTH;
    end
    busy_end = captured ? done_edge : abort_n;
    stop_min = captured ? done_edge : abort_n;
    for (int n = 0; ; n++) begin
      probe_signal = (n < pq.size()) ? pq[n] : pq[pq.size()-1];
      arm          = (n == a_idx) || (n > a_idx && (abort_n < 0 || n < abort_n) &&
                                      $urandom_range(0, 3) == 0);
      trig_mode    = (n == a_idx) ? 2'(mode) : 2'($urandom_range(0, 3));
      trig_ch      = (n == a_idx) ? CW'(ch) : CW'($urandom_range(0, 7));
      abort        = (n == abort_n);
      rd_ready     = (n == abort_n) ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
      @(posedge clk);
      #1;
      check({tag, "_done"}, done, (n == done_edge));
      check({tag, "_busy"}, busy, armed_ok && n >= a_idx && n < busy_end);
      if (n == abort_n) begin
        check({tag, "_abort_valid"}, rd_valid, 1'b0);
        exp_q.delete();
      end
      if (n >= stop_min && n >= a_idx && exp_q.size() == 0 && !busy && !rd_valid) break;
      if (n >= 3000) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout: still busy=%0b rd_valid=%0b after %0d cycles", tag, busy, rd_valid, n);
        abort = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        break;
      end
    end
    arm   = 1'b0;
    abort = 1'b0;
  endtask

  logic [CH-1:0] pq[$];
  logic [CH-1:0] v;

  initial begin
    rst_n = 1'b0; probe_signal = '1; arm = 0; abort = 0; rd_ready = 1;
    trig_mode = 0; trig_ch = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_last", rd_last, 0);
    check("rst_data", rd_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    pq = {}; for (int n = 0; n < 30; n++) pq.push_back(CH'($urandom));
    run_scn("imm", pq, 2, 0, 0, -1, 0);

    pq = {}; for (int n = 0; n < 45; n++) pq.push_back((CH'(n) & ~8'h08) | (n >= 22 ? 8'h08 : 8'h00));
    run_scn("rise3", pq, 2, 1, 3, -1, 0);

    pq = {}; for (int n = 0; n < 40; n++) begin v = CH'($urandom); v[7] = (n < 15); pq.push_back(v); end
    run_scn("fall7", pq, 3, 2, 7, -1, 0);

    v = CH'($urandom);
    pq = {}; for (int n = 0; n < 40; n++) pq.push_back(n < 18 ? v : v ^ 8'h20);
    run_scn("tog5", pq, 2, 3, 0, -1, 0);

    pq = {}; for (int n = 0; n < 60; n++) pq.push_back(v);
    run_scn("const", pq, 2, 3, 0, 60, 0);

    pq = {}; for (int n = 0; n < 30; n++) pq.push_back(CH'($urandom));
    run_scn("bp_imm", pq, 2, 0, 0, -1, 1);
    pq = {}; for (int n = 0; n < 40; n++) pq.push_back(CH'($urandom));
    run_scn("bp_rise", pq, 2, 1, 5, -1, 1);

    pq = {}; for (int n = 0; n < 20; n++) pq.push_back(CH'($urandom) & ~8'h08);
    run_scn("ab_armed", pq, 2, 1, 3, 7, 0);
    pq = {}; for (int n = 0; n < 30; n++) pq.push_back(CH'($urandom));
    run_scn("ab_cap", pq, 2, 0, 0, 10, 0);
    run_scn("ab_rd", pq, 2, 0, 0, 2 + DEPTH + 5, 0);
    run_scn("ab_arm", pq, 2, 0, 0, 2, 0);
    run_scn("post_ab", pq, 2, 0, 0, -1, 1);

    // Reset in the middle of a capture.
    probe_signal = CH'($urandom); arm = 1; trig_mode = 0; trig_ch = 0;
    @(posedge clk); #1;
    arm = 0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_last", rd_last, 0);
    check("mid_rst_data", rd_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 6; r++) begin
      pq = {}; for (int n = 0; n < 60; n++) pq.push_back(CH'($urandom));
      run_scn("rand", pq, 2, $urandom_range(0, 3), $urandom_range(0, 7), -1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
